// File: rtl/mem_pkg.sv
// mem_pkg: shared mem_cmd encodings and the bridge address map (RAM below RAM_TOP, I/O registers above)
package mem_pkg;
  typedef enum logic [1:0] {MNONE = 2'b00, MREAD = 2'b01, MWRITE = 2'b10} mem_cmd_e;
  localparam logic [8:0] RAM_TOP     = 9'h0FF;
  localparam logic [8:0] ADDR_LED    = 9'h100;
  localparam logic [8:0] ADDR_SW     = 9'h140;
  localparam logic [8:0] ADDR_TCOUNT = 9'h180;
  localparam logic [8:0] ADDR_TCMP   = 9'h181;
  localparam logic [8:0] ADDR_TCTRL  = 9'h182;
  localparam logic [8:0] ADDR_TSTAT  = 9'h183;
endpackage

// File: rtl/mem_io_bridge_if.sv
// mem_io_bridge_if: CPU memory bus (mem_cmd, mem_addr, write_data in; read_data out) with master/slave modports
import mem_pkg::*;
interface mem_io_bridge_if;
  mem_cmd_e    mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic [15:0] read_data;
  modport master (output mem_cmd, mem_addr, write_data, input read_data);
  modport slave (input mem_cmd, mem_addr, write_data, output read_data);
endinterface

// File: rtl/mem_io_bridge_io_timer.sv
// io_timer: prescaled compare timer with sticky read-to-clear flag; ports clk/reset, decoded write/read strobes, i_wdata, register views o_count/o_cmp/o_en/o_flag
module io_timer #(
  parameter int PRESCALE = 50
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_wr_count,
  input  logic        i_wr_cmp,
  input  logic        i_wr_ctrl,
  input  logic        i_rd_stat,
  input  logic [15:0] i_wdata,
  output logic [15:0] o_count,
  output logic [15:0] o_cmp,
  output logic        o_en,
  output logic        o_flag
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  logic [PW-1:0] r_pre;
  logic [15:0]   r_count, r_cmp;
  logic          r_en, r_flag;
  logic          w_tick, w_hit;
  assign w_tick = r_en && (r_pre == PW'(PRESCALE - 1));
  assign w_hit  = w_tick && (r_count == r_cmp);
  always_ff @(posedge clk)
    if (reset) begin
      r_pre   <= '0;
      r_count <= '0;
      r_cmp   <= 16'hFFFF;
      r_en    <= 1'b0;
      r_flag  <= 1'b0;
    end else begin
      r_pre   <= i_wr_ctrl ? '0 : !r_en ? r_pre : w_tick ? '0 : r_pre + PW'(1);
      r_count <= i_wr_count ? i_wdata : w_hit ? '0 : w_tick ? r_count + 16'd1 : r_count;
      if (i_wr_cmp) r_cmp <= i_wdata;
      if (i_wr_ctrl) r_en <= i_wdata[0];
      r_flag  <= w_hit | (r_flag & ~i_rd_stat);
    end
  assign o_count = r_count;
  assign o_cmp   = r_cmp;
  assign o_en    = r_en;
  assign o_flag  = r_flag;
endmodule

// File: rtl/mem_io_bridge.sv
// mem_io_bridge: decodes CPU accesses to RAM or I/O (LED, synchronized switches, io_timer); ports clk/reset, bus slave, ram_dout/ram_write, sw_in, led_out, timer_irq
module mem_io_bridge import mem_pkg::*; #(
  parameter int PRESCALE = 50,
  parameter int SW_W     = 8
) (
  input  logic            clk,
  input  logic            reset,
  mem_io_bridge_if.slave  bus,
  input  logic [15:0]     ram_dout,
  output logic            ram_write,
  input  logic [SW_W-1:0] sw_in,
  output logic [SW_W-1:0] led_out,
  output logic            timer_irq
);
  logic            w_wr, w_rd, w_ram;
  logic [SW_W-1:0] r_led, r_sw1, r_sw2;
  logic [15:0]     w_count, w_cmp;
  logic            w_en, w_flag;
  assign w_wr      = bus.mem_cmd == MWRITE;
  assign w_rd      = bus.mem_cmd == MREAD;
  assign w_ram     = bus.mem_addr <= RAM_TOP;
  assign ram_write = w_wr && w_ram;
  io_timer #(.PRESCALE(PRESCALE)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .i_wr_count(w_wr && bus.mem_addr == ADDR_TCOUNT),
    .i_wr_cmp  (w_wr && bus.mem_addr == ADDR_TCMP),
    .i_wr_ctrl (w_wr && bus.mem_addr == ADDR_TCTRL),
    .i_rd_stat (w_rd && bus.mem_addr == ADDR_TSTAT),
    .i_wdata   (bus.write_data),
    .o_count   (w_count),
    .o_cmp     (w_cmp),
    .o_en      (w_en),
    .o_flag    (w_flag)
  );
  always_ff @(posedge clk)
    if (reset) begin
      r_led <= '0;
      r_sw1 <= '0;
      r_sw2 <= '0;
    end else begin
      r_sw1 <= sw_in;
      r_sw2 <= r_sw1;
      if (w_wr && bus.mem_addr == ADDR_LED) r_led <= bus.write_data[SW_W-1:0];
    end
  always_comb
    bus.read_data = !w_rd                      ? 16'h0000 :
                    w_ram                      ? ram_dout :
                    bus.mem_addr == ADDR_LED    ? 16'(r_led) :
                    bus.mem_addr == ADDR_SW     ? 16'(r_sw2) :
                    bus.mem_addr == ADDR_TCOUNT ? w_count :
                    bus.mem_addr == ADDR_TCMP   ? w_cmp :
                    bus.mem_addr == ADDR_TCTRL  ? {15'b0, w_en} :
                    bus.mem_addr == ADDR_TSTAT  ? {15'b0, w_flag} : 16'h0000;
  assign led_out   = r_led;
  assign timer_irq = w_flag;
endmodule

// File: tb/tb_mem_io_bridge.sv
// tb_mem_io_bridge: directed and randomized checks of mem_io_bridge against a behavioural model
module tb_mem_io_bridge;
  import mem_pkg::*;
  localparam int P = 2;
  logic        clk = 0, reset = 1;
  logic [15:0] ram_dout = 0, ram_nx = 0;
  logic        ram_write, timer_irq;
  logic [7:0]  sw_in = 0, sw_nx = 0, led_out;
  mem_io_bridge_if bus();
  mem_io_bridge #(.PRESCALE(P), .SW_W(8)) dut (
    .clk(clk), .reset(reset), .bus(bus), .ram_dout(ram_dout), .ram_write(ram_write),
    .sw_in(sw_in), .led_out(led_out), .timer_irq(timer_irq)
  );
  always #5 clk = ~clk;
  int errs = 0, checks = 0;
  bit armed = 0;
  logic [7:0]  m_led;
  logic [15:0] m_cnt, m_cmp;
  bit          m_en, m_flag, tick, hit, wr, rd;
  int          m_phase;
  logic [8:0]  a;
  logic [7:0]  hist[$];
  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(posedge clk)
    if (reset) begin
      m_led = 0; m_cnt = 0; m_cmp = 16'hFFFF; m_en = 0; m_flag = 0; m_phase = 0;
      hist = '{8'h00, 8'h00};
      armed = 1;
    end else begin
      a = bus.mem_addr;
      wr = bus.mem_cmd == MWRITE;
      rd = bus.mem_cmd == MREAD;
      tick = m_en && m_phase == P - 1;
      hit = tick && m_cnt == m_cmp;
      hist.push_front(sw_in);
      if (hist.size() > 3) void'(hist.pop_back());
      if (wr && a == ADDR_LED) m_led = bus.write_data[7:0];
      m_flag = hit || (m_flag && !(rd && a == ADDR_TSTAT));
      if (wr && a == ADDR_TCOUNT) m_cnt = bus.write_data;
      else if (tick) m_cnt = hit ? 16'h0 : m_cnt + 16'h1;
      m_phase = (wr && a == ADDR_TCTRL) ? 0 : m_en ? (m_phase + 1) % P : m_phase;
      if (wr && a == ADDR_TCMP) m_cmp = bus.write_data;
      if (wr && a == ADDR_TCTRL) m_en = bus.write_data[0];
    end
  function automatic logic [15:0] exp_rd();
    logic [8:0] x = bus.mem_addr;
    if (bus.mem_cmd != MREAD) return 16'h0;
    if (!x[8]) return ram_dout;
    case (x)
      ADDR_LED:    return {8'h0, m_led};
      ADDR_SW:     return {8'h0, hist[1]};
      ADDR_TCOUNT: return m_cnt;
      ADDR_TCMP:   return m_cmp;
      ADDR_TCTRL:  return {15'b0, m_en};
      ADDR_TSTAT:  return {15'b0, m_flag};
      default:     return 16'h0;
    endcase
  endfunction
  always @(negedge clk)
    if (armed) begin
      chk("read_data", bus.read_data, exp_rd());
      chk("ram_write", {15'b0, ram_write}, {15'b0, bus.mem_cmd == MWRITE && !bus.mem_addr[8]});
      chk("led_out", {8'h0, led_out}, {8'h0, m_led});
      chk("timer_irq", {15'b0, timer_irq}, {15'b0, m_flag});
    end
  task automatic put(bit r, mem_cmd_e c, logic [8:0] ad, logic [15:0] d);
    @(posedge clk);
    #1;
    reset = r; bus.mem_cmd = c; bus.mem_addr = ad; bus.write_data = d;
    sw_in = sw_nx; ram_dout = ram_nx;
    @(negedge clk);
  endtask
  logic [8:0] unm[5] = '{9'h101, 9'h1F0, 9'h184, 9'h141, 9'h1FF};
  initial begin
    bus.mem_cmd = MNONE; bus.mem_addr = 0; bus.write_data = 0;
    put(1, MNONE, 0, 0);
    put(1, MNONE, 0, 0);
    put(0, MREAD, ADDR_TCMP, 0);
    chk("rst_tcmp", bus.read_data, 16'hFFFF);
    chk("rst_led", {8'h0, led_out}, 16'h0);
    chk("rst_irq", {15'b0, timer_irq}, 16'h0);
    put(0, MWRITE, ADDR_LED, 16'h00A5);
    put(0, MREAD, ADDR_LED, 0);
    chk("led_wr", {8'h0, led_out}, 16'h00A5);
    chk("led_rd", bus.read_data, 16'h00A5);
    put(1, MNONE, 0, 0);
    put(0, MNONE, 0, 0);
    chk("led_rst", {8'h0, led_out}, 16'h0);
    put(0, MWRITE, 9'h03F, 16'hBEEF);
    chk("ram_we", {15'b0, ram_write}, 16'h1);
    ram_nx = 16'h1234;
    put(0, MREAD, 9'h03F, 0);
    chk("ram_rd", bus.read_data, 16'h1234);
    put(0, MWRITE, ADDR_LED, 16'h0011);
    chk("ram_we_io", {15'b0, ram_write}, 16'h0);
    sw_nx = 8'h5A;
    put(0, MREAD, ADDR_SW, 0);
    chk("sw_k0", bus.read_data, 16'h0);
    put(0, MREAD, ADDR_SW, 0);
    chk("sw_k1", bus.read_data, 16'h0);
    put(0, MREAD, ADDR_SW, 0);
    chk("sw_k2", bus.read_data, 16'h005A);
    put(0, MWRITE, ADDR_TCMP, 16'd3);
    put(0, MWRITE, ADDR_TCTRL, 16'd1);
    for (int i = 0; i <= 8; i++) begin
      put(0, MREAD, ADDR_TCOUNT, 0);
      chk("tcount_seq", bus.read_data, (i == 8) ? 16'd0 : 16'(i / 2));
      chk("irq_seq", {15'b0, timer_irq}, {15'b0, i == 8});
    end
    put(0, MREAD, ADDR_TSTAT, 0);
    chk("tstat_rd", bus.read_data, 16'h1);
    put(0, MNONE, 0, 0);
    chk("tstat_clr", {15'b0, timer_irq}, 16'h0);
    put(0, MWRITE, ADDR_TCTRL, 16'd0);
    put(0, MWRITE, ADDR_TCMP, 16'hFFFE);
    put(0, MWRITE, ADDR_TCOUNT, 16'hFFFF);
    put(0, MWRITE, ADDR_TCTRL, 16'd1);
    put(0, MREAD, ADDR_TCOUNT, 0);
    chk("wrap_e0", bus.read_data, 16'hFFFF);
    put(0, MREAD, ADDR_TCOUNT, 0);
    chk("wrap_e1", bus.read_data, 16'hFFFF);
    put(0, MREAD, ADDR_TCOUNT, 0);
    chk("wrap_e2", bus.read_data, 16'h0);
    chk("wrap_noflag", {15'b0, timer_irq}, 16'h0);
    put(0, MWRITE, ADDR_TCOUNT, 16'h1234);
    put(0, MREAD, ADDR_TCOUNT, 0);
    chk("wr_beats_tick", bus.read_data, 16'h1234);
    put(0, MWRITE, ADDR_TCTRL, 16'd0);
    put(0, MWRITE, ADDR_TCMP, 16'd5);
    put(0, MWRITE, ADDR_TCOUNT, 16'd5);
    put(0, MWRITE, ADDR_TCTRL, 16'd1);
    put(0, MNONE, 0, 0);
    put(0, MREAD, ADDR_TSTAT, 0);
    chk("set_vs_clr_rd", bus.read_data, 16'h0);
    put(0, MNONE, 0, 0);
    chk("set_beats_clr", {15'b0, timer_irq}, 16'h1);
    put(0, MREAD, ADDR_TSTAT, 0);
    put(0, MWRITE, ADDR_TCTRL, 16'd0);
    put(0, MREAD, 9'h1F0, 0);
    chk("unmapped_rd", bus.read_data, 16'h0);
    put(0, MWRITE, ADDR_SW, 16'h00FF);
    put(0, MREAD, ADDR_SW, 0);
    chk("sw_ro", bus.read_data, 16'h005A);
    for (int n = 0; n < 3000; n++) begin
      int k = $urandom_range(0, 9);
      int cr = $urandom_range(0, 3);
      mem_cmd_e c = (cr == 0) ? MNONE : (cr == 3) ? MWRITE : MREAD;
      logic [8:0] ad;
      logic [15:0] d = 16'($urandom);
      case (k)
        0, 1: ad = 9'($urandom_range(0, 255));
        2: ad = ADDR_LED;
        3: ad = ADDR_SW;
        4: begin
          ad = ADDR_TCOUNT;
          if ($urandom_range(0, 3) != 0) d = ($urandom_range(0, 1) != 0) ? 16'hFFFF : 16'($urandom_range(0, 6));
        end
        5: begin
          ad = ADDR_TCMP;
          if ($urandom_range(0, 7) != 0) d = 16'($urandom_range(0, 6));
        end
        6: begin
          ad = ADDR_TCTRL;
          d = {15'b0, $urandom_range(0, 3) != 0};
        end
        8: ad = unm[$urandom_range(0, 4)];
        default: ad = ADDR_TSTAT;
      endcase
      if ($urandom_range(0, 7) == 0) sw_nx = 8'($urandom);
      ram_nx = 16'($urandom);
      put($urandom_range(0, 299) == 0, c, ad, d);
    end
    put(0, MNONE, 0, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
